gpu_cmd_parser: RTL and testbench

Front end of the GPU. Accepts 32-bit command words from the host over a dv/ready word handshake and assembles multi-word commands: Swap, Pixel, Rect and Fill. It validates and clips each command against the screen and issues one decoded command per valid/ready transfer to the downstream draw engine. It holds Swap until the engine is idle.

---
 rtl/gpu_pkg.sv | 40 ++++
 rtl/gpu_cmd_parser_if.sv | 31 +++
 rtl/gpu_clip.sv | 37 +++
 rtl/gpu_cmd_parser.sv | 158 +++++++++++++++
 tb/tb_gpu_cmd_parser.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU front end: host opcodes, decoded
// command struct, parser states and default screen geometry.
package gpu_pkg;

  localparam logic [15:0] GPU_CMD_NOP   = 16'h0000;
  localparam logic [15:0] GPU_CMD_SWAP  = 16'h0001;
  localparam logic [15:0] GPU_CMD_PIXEL = 16'h0002;
  localparam logic [15:0] GPU_CMD_RECT  = 16'h0003;
  localparam logic [15:0] GPU_CMD_FILL  = 16'h0004;

  localparam int unsigned SCREEN_W_DEF = 800;
  localparam int unsigned SCREEN_H_DEF = 600;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_SWAP  = 3'd1,
    OP_PIXEL = 3'd2,
    OP_RECT  = 3'd3,
    OP_FILL  = 3'd4
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [1:0]  color;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
  } cmd_t;

  typedef enum logic [2:0] {
    S_HDR,
    S_ARG_XY,
    S_ARG_WH,
    S_CLIP,
    S_SWAP_WAIT,
    S_ISSUE
  } parser_state_t;

endpackage

// File: rtl/gpu_cmd_parser_if.sv
// Host word handshake plus decoded-command handshake to the draw engine.
interface gpu_cmd_parser_if;
  import gpu_pkg::*;

  logic        dv;
  logic [31:0] din;
  logic        ready;
  logic        cmd_valid;
  logic        cmd_ready;
  op_t         cmd_op;
  logic [1:0]  cmd_color;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic [15:0] cmd_w;
  logic [15:0] cmd_h;
  logic        engine_busy;
  logic [7:0]  drop_cnt;

  modport master (
    output dv, din, cmd_ready, engine_busy,
    input  ready, cmd_valid, cmd_op, cmd_color, cmd_x, cmd_y, cmd_w, cmd_h,
           drop_cnt
  );

  modport slave (
    input  dv, din, cmd_ready, engine_busy,
    output ready, cmd_valid, cmd_op, cmd_color, cmd_x, cmd_y, cmd_w, cmd_h,
           drop_cnt
  );

endinterface

// File: rtl/gpu_clip.sv
// Combinational validate/clip of a rectangle against the screen: flags
// off-screen or empty rectangles and trims the extent to the screen edge.
module gpu_clip
  import gpu_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] w_i,
  input  logic [15:0] h_i,
  output logic [15:0] w_o,
  output logic [15:0] h_o,
  output logic        drop_o
);

  localparam logic [16:0] SW = 17'(SCREEN_W);
  localparam logic [16:0] SH = 17'(SCREEN_H);

  logic [16:0] x_end;
  logic [16:0] y_end;
  logic [16:0] w_rem;
  logic [16:0] h_rem;

  always_comb begin
    x_end  = {1'b0, x_i} + {1'b0, w_i};
    y_end  = {1'b0, y_i} + {1'b0, h_i};
    w_rem  = SW - {1'b0, x_i};
    h_rem  = SH - {1'b0, y_i};
    drop_o = ({1'b0, x_i} >= SW) || ({1'b0, y_i} >= SH) ||
             (w_i == '0) || (h_i == '0);
    w_o    = (x_end > SW) ? w_rem[15:0] : w_i;
    h_o    = (y_end > SH) ? h_rem[15:0] : h_i;
  end

endmodule

// File: rtl/gpu_cmd_parser.sv
// GPU command front end: assembles multi-word host commands, clips them to
// the screen and hands one decoded command at a time to the draw engine.
module gpu_cmd_parser
  import gpu_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  gpu_cmd_parser_if.slave   bus
);

  parser_state_t state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          ready_q, ready_d;
  logic          accept;
  logic          drop_evt;
  logic [15:0]   clip_w;
  logic [15:0]   clip_h;
  logic          clip_drop;

  gpu_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x_i    (cmd_q.x),
    .y_i    (cmd_q.y),
    .w_i    (cmd_q.w),
    .h_i    (cmd_q.h),
    .w_o    (clip_w),
    .h_o    (clip_h),
    .drop_o (clip_drop)
  );

  // ready is registered from the next state so it stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      cmd_q      <= '0;
      drop_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      drop_cnt_q <= drop_cnt_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    drop_cnt_d = drop_cnt_q;
    drop_evt   = 1'b0;
    accept     = bus.dv & ready_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (bus.din[31:18] != '0) begin
            drop_evt = 1'b1;
          end else begin
            case (bus.din[15:0])
              GPU_CMD_NOP: begin
                state_d = S_HDR;
              end
              GPU_CMD_SWAP: begin
                cmd_d       = '0;
                cmd_d.op    = OP_SWAP;
                cmd_d.color = bus.din[17:16];
                // Idle engine skips the wait state so Swap issues next cycle.
                state_d     = bus.engine_busy ? S_SWAP_WAIT : S_ISSUE;
              end
              GPU_CMD_PIXEL: begin
                cmd_d       = '0;
                cmd_d.op    = OP_PIXEL;
                cmd_d.color = bus.din[17:16];
                state_d     = S_ARG_XY;
              end
              GPU_CMD_RECT: begin
                cmd_d       = '0;
                cmd_d.op    = OP_RECT;
                cmd_d.color = bus.din[17:16];
                state_d     = S_ARG_XY;
              end
              GPU_CMD_FILL: begin
                cmd_d       = '0;
                cmd_d.op    = OP_FILL;
                cmd_d.color = bus.din[17:16];
                cmd_d.w     = 16'(SCREEN_W);
                cmd_d.h     = 16'(SCREEN_H);
                state_d     = S_ISSUE;
              end
              default: drop_evt = 1'b1;
            endcase
          end
        end
      end
      S_ARG_XY: begin
        if (accept) begin
          cmd_d.x = bus.din[15:0];
          cmd_d.y = bus.din[31:16];
          if (cmd_q.op == OP_PIXEL) begin
            cmd_d.w = 16'd1;
            cmd_d.h = 16'd1;
            state_d = S_CLIP;
          end else begin
            state_d = S_ARG_WH;
          end
        end
      end
      S_ARG_WH: begin
        if (accept) begin
          cmd_d.w = bus.din[15:0];
          cmd_d.h = bus.din[31:16];
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        if (clip_drop) begin
          drop_evt = 1'b1;
          state_d  = S_HDR;
        end else begin
          cmd_d.w = clip_w;
          cmd_d.h = clip_h;
          state_d = S_ISSUE;
        end
      end
      S_SWAP_WAIT: begin
        if (!bus.engine_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.cmd_ready) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 8'd1;

    ready_d = (state_d == S_HDR) || (state_d == S_ARG_XY) ||
              (state_d == S_ARG_WH);
  end

  always_comb begin
    bus.ready     = ready_q;
    bus.cmd_valid = (state_q == S_ISSUE);
    bus.cmd_op    = cmd_q.op;
    bus.cmd_color = cmd_q.color;
    bus.cmd_x     = cmd_q.x;
    bus.cmd_y     = cmd_q.y;
    bus.cmd_w     = cmd_q.w;
    bus.cmd_h     = cmd_q.h;
    bus.drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// Directed scoreboard bench for gpu_cmd_parser.
module tb_gpu_cmd_parser;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_cmd_parser_if bus ();

  gpu_cmd_parser #(
    .SCREEN_W (800),
    .SCREEN_H (600)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          exp_drop = 0;
  cmd_t        exp_q[$];

  function automatic cmd_t mk(input op_t op, input logic [1:0] c,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] w, input logic [15:0] h);
    cmd_t r;
    r.op = op; r.color = c; r.x = x; r.y = y; r.w = w; r.h = h;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int unsigned n = 0;
    bus.dv  = 1'b1;
    bus.din = w;
    while (!bus.ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.ready) chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
    tick();
    bus.dv  = 1'b0;
    bus.din = '0;
  endtask

  task automatic expect_cmd(input string tag);
    cmd_t e;
    int unsigned n = 0;
    while (!bus.cmd_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, (exp_q.size() != 0)}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_op"},    {29'd0, bus.cmd_op},    {29'd0, e.op});
    chk({tag, "_color"}, {30'd0, bus.cmd_color}, {30'd0, e.color});
    chk({tag, "_x"},     {16'd0, bus.cmd_x},     {16'd0, e.x});
    chk({tag, "_y"},     {16'd0, bus.cmd_y},     {16'd0, e.y});
    chk({tag, "_w"},     {16'd0, bus.cmd_w},     {16'd0, e.w});
    chk({tag, "_h"},     {16'd0, bus.cmd_h},     {16'd0, e.h});
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.cmd_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dv          = 1'b0;
    bus.din         = '0;
    bus.cmd_ready   = 1'b0;
    bus.engine_busy = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("rst_drop",  {24'd0, bus.drop_cnt}, 32'd0);
    chk("rst_op",    {29'd0, bus.cmd_op}, 32'd0);
    chk("rst_x",     {16'd0, bus.cmd_x}, 32'd0);
    chk("rst_w",     {16'd0, bus.cmd_w}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, bus.ready}, 32'd1);

    // Swap with idle engine: valid the cycle after accept
    exp_q.push_back(mk(OP_SWAP, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0));
    send(32'h0000_0001);
    chk("swap_lat", {31'd0, bus.cmd_valid}, 32'd1);
    expect_cmd("swap");

    // Pixel, held off by engine for 5 cycles
    exp_q.push_back(mk(OP_PIXEL, 2'd1, 16'd200, 16'd300, 16'd1, 16'd1));
    send(32'h0001_0002);
    send({16'd300, 16'd200});
    chk("pixel_clip_cycle", {31'd0, bus.cmd_valid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("pixel_hold_valid", {31'd0, bus.cmd_valid}, 32'd1);
      chk("pixel_hold_ready", {31'd0, bus.ready}, 32'd0);
      chk("pixel_hold_x", {16'd0, bus.cmd_x}, 32'd200);
      chk("pixel_hold_y", {16'd0, bus.cmd_y}, 32'd300);
      tick();
    end
    expect_cmd("pixel");

    // Full-width rect, unclipped
    exp_q.push_back(mk(OP_RECT, 2'd2, 16'd0, 16'd0, 16'd800, 16'd300));
    send(32'h0002_0003);
    send(32'h0000_0000);
    send({16'd300, 16'd800});
    chk("rect_clip_cycle", {31'd0, bus.cmd_valid}, 32'd0);
    tick();
    chk("rect_lat", {31'd0, bus.cmd_valid}, 32'd1);
    expect_cmd("rect_full");

    // Rect straddling bottom-right corner
    exp_q.push_back(mk(OP_RECT, 2'd0, 16'd790, 16'd590, 16'd10, 16'd10));
    send(32'h0000_0003);
    send({16'd590, 16'd790});
    send({16'd50, 16'd50});
    expect_cmd("rect_clip");

    // Rect with x at the screen edge is dropped
    send(32'h0000_0003);
    send({16'd0, 16'd800});
    send({16'd10, 16'd10});
    tick();
    exp_drop++;
    chk("drop_x_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("drop_x_cnt", {24'd0, bus.drop_cnt}, exp_drop);

    // Rect with zero width is dropped
    send(32'h0000_0003);
    send({16'd10, 16'd10});
    send({16'd5, 16'd0});
    tick();
    exp_drop++;
    chk("drop_w0_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("drop_w0_cnt", {24'd0, bus.drop_cnt}, exp_drop);

    // Unknown opcode and reserved header bits
    send(32'h0000_0009);
    exp_drop++;
    chk("drop_op9_cnt", {24'd0, bus.drop_cnt}, exp_drop);
    chk("drop_op9_valid", {31'd0, bus.cmd_valid}, 32'd0);
    send(32'h0004_0001);
    exp_drop++;
    chk("drop_rsvd_cnt", {24'd0, bus.drop_cnt}, exp_drop);

    // Nop consumes silently
    send(32'h0000_0000);
    chk("nop_cnt", {24'd0, bus.drop_cnt}, exp_drop);
    chk("nop_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("nop_ready", {31'd0, bus.ready}, 32'd1);

    // Swap held while the engine is busy
    bus.engine_busy = 1'b1;
    exp_q.push_back(mk(OP_SWAP, 2'd3, 16'd0, 16'd0, 16'd0, 16'd0));
    send(32'h0003_0001);
    for (int i = 0; i < 20; i++) begin
      chk("swap_busy_valid", {31'd0, bus.cmd_valid}, 32'd0);
      chk("swap_busy_ready", {31'd0, bus.ready}, 32'd0);
      tick();
    end
    bus.engine_busy = 1'b0;
    chk("swap_busy_fall", {31'd0, bus.cmd_valid}, 32'd0);
    tick();
    chk("swap_busy_lat", {31'd0, bus.cmd_valid}, 32'd1);
    expect_cmd("swap_busy");

    // Rect with 3-cycle dv gaps between words
    exp_q.push_back(mk(OP_RECT, 2'd1, 16'd10, 16'd20, 16'd30, 16'd40));
    send(32'h0001_0003);
    for (int i = 0; i < 3; i++) begin
      chk("gap1_valid", {31'd0, bus.cmd_valid}, 32'd0);
      tick();
    end
    send({16'd20, 16'd10});
    for (int i = 0; i < 3; i++) begin
      chk("gap2_valid", {31'd0, bus.cmd_valid}, 32'd0);
      chk("gap2_ready", {31'd0, bus.ready}, 32'd1);
      tick();
    end
    send({16'd40, 16'd30});
    expect_cmd("rect_gaps");

    // Reset in the middle of a Rect, then Fill
    send(32'h0000_0003);
    send({16'd5, 16'd5});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_drop = 0;
    chk("midrst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst_drop", {24'd0, bus.drop_cnt}, exp_drop);
    chk("midrst_x", {16'd0, bus.cmd_x}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_rel_ready", {31'd0, bus.ready}, 32'd1);
    exp_q.push_back(mk(OP_FILL, 2'd0, 16'd0, 16'd0, 16'd800, 16'd600));
    send(32'h0000_0004);
    chk("fill_lat", {31'd0, bus.cmd_valid}, 32'd1);
    expect_cmd("fill");

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) begin
      send(32'h0000_00FF);
      if (exp_drop < 255) exp_drop++;
      if (i == 253 || i == 254 || i == 299)
        chk("sat_cnt", {24'd0, bus.drop_cnt}, exp_drop);
    end
    chk("sat_final", {24'd0, bus.drop_cnt}, 32'd255);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
